// File: rtl/dm_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter.
// Holds the fill FSM encoding, default sizes and the address-width helper.
package dm_access_arbiter_pkg;

  localparam int DM_LENGTH = 16;
  localparam int DM_DEPTH  = 256;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_DONE = 2'd2
  } fill_state_e;

  // ceil(log2(n)), never less than 1 so a width is always legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_access_arbiter_fill.sv
// Fill sequencer: writes one latched value to every data-memory word,
// one word per cycle, then pulses fill_done for a single cycle.
module dm_fill_seq
  import dm_access_arbiter_pkg::*;
#(
  parameter  int LENGTH         = DM_LENGTH,
  parameter  int DATA_MEM_DEPTH = DM_DEPTH,
  localparam int ADDR_W         = clog2_min1(DATA_MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [LENGTH-1:0] fill_value,
  output logic              fill_run,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LENGTH-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done
);

  // Termination is by compare so a non power-of-two depth never relies on wrap.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_MEM_DEPTH - 1);

  fill_state_e state, state_next;

  always_comb begin
    // NOTE: the default comes first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      F_IDLE:  if (fill_start) state_next = F_RUN;
      F_RUN:   if (fill_addr == LAST_ADDR) state_next = F_DONE;
      F_DONE:  state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= F_IDLE;
      fill_addr <= '0;
      fill_data <= '0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      state     <= state_next;
      fill_busy <= (state_next != F_IDLE);
      fill_done <= (state_next == F_DONE);
      if (state == F_IDLE && fill_start) begin
        fill_addr <= '0;
        fill_data <= fill_value;
      end else if (state == F_RUN) begin
        fill_addr <= fill_addr + 1'b1;
      end
    end
  end

  assign fill_run = (state == F_RUN);

endmodule

// File: rtl/dm_access_arbiter.sv
// Single-port data-memory access controller: arbitrates core, external port
// and the fill sequencer onto the memory port, returning registered read data.
module dm_access_arbiter
  import dm_access_arbiter_pkg::*;
#(
  parameter  int LENGTH         = DM_LENGTH,
  parameter  int DATA_MEM_DEPTH = DM_DEPTH,
  parameter  int STARVE_LIMIT   = 4,
  localparam int ADDR_W         = clog2_min1(DATA_MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [LENGTH-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [LENGTH-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [LENGTH-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [LENGTH-1:0] ext_rdata,
  input  logic              fill_start,
  input  logic [LENGTH-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_writeMem,
  output logic [LENGTH-1:0] mem_writeData,
  output logic [ADDR_W-1:0] mem_dataAddr,
  input  logic [LENGTH-1:0] mem_data_out
);

  localparam int                  STARVE_W   = clog2_min1(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                fill_run;
  logic                fill_active;
  logic [ADDR_W-1:0]   fill_addr;
  logic [LENGTH-1:0]   fill_data;
  logic [STARVE_W-1:0] starve_cnt;

  dm_fill_seq #(
    .LENGTH         (LENGTH),
    .DATA_MEM_DEPTH (DATA_MEM_DEPTH)
  ) u_fill (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_run   (fill_run),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // Nothing reaches the memory port while reset is asserted, fill included.
  assign fill_active = reset_n && fill_run;

  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (reset_n && !fill_run) begin
      if (ext_req && starve_cnt == STARVE_MAX) ext_gnt  = 1'b1;
      else if (core_req)                       core_gnt = 1'b1;
      else if (ext_req)                        ext_gnt  = 1'b1;
    end

    mem_writeMem  = 1'b0;
    mem_writeData = '0;
    mem_dataAddr  = '0;
    if (fill_active) begin
      mem_writeMem  = 1'b1;
      mem_writeData = fill_data;
      mem_dataAddr  = fill_addr;
    end else if (core_gnt) begin
      mem_writeMem  = core_we;
      mem_writeData = core_wdata;
      mem_dataAddr  = core_addr;
    end else if (ext_gnt) begin
      mem_writeMem  = ext_we;
      mem_writeData = ext_wdata;
      mem_dataAddr  = ext_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt  <= '0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      ext_rvalid  <= 1'b0;
      ext_rdata   <= '0;
    end else begin
      if (ext_gnt || !ext_req)                       starve_cnt <= '0;
      else if (core_gnt && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;

      // rdata only moves on a read grant to its own port and holds otherwise.
      core_rvalid <= core_gnt && !core_we;
      if (core_gnt && !core_we) core_rdata <= mem_data_out;
      ext_rvalid  <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: a memory model on the port, a
// cycle-level reference model checked every negedge, plus directed literal checks.
module tb_dm_access_arbiter;

  localparam int LENGTH       = 16;
  localparam int DEPTH        = 256;
  localparam int AW           = 8;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0]     core_addr = '0;
  logic [LENGTH-1:0] core_wdata = '0;
  logic              ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0]     ext_addr = '0;
  logic [LENGTH-1:0] ext_wdata = '0;
  logic              fill_start = 1'b0;
  logic [LENGTH-1:0] fill_value = '0;

  logic              core_gnt, core_rvalid, ext_gnt, ext_rvalid;
  logic [LENGTH-1:0] core_rdata, ext_rdata;
  logic              fill_busy, fill_done, mem_writeMem;
  logic [LENGTH-1:0] mem_writeData, mem_data_out;
  logic [AW-1:0]     mem_dataAddr;

  logic [LENGTH-1:0] mem [DEPTH] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(
    .LENGTH         (LENGTH),
    .DATA_MEM_DEPTH (DEPTH),
    .STARVE_LIMIT   (STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_gnt      (core_gnt),
    .core_rvalid   (core_rvalid),
    .core_rdata    (core_rdata),
    .ext_req       (ext_req),
    .ext_we        (ext_we),
    .ext_addr      (ext_addr),
    .ext_wdata     (ext_wdata),
    .ext_gnt       (ext_gnt),
    .ext_rvalid    (ext_rvalid),
    .ext_rdata     (ext_rdata),
    .fill_start    (fill_start),
    .fill_value    (fill_value),
    .fill_busy     (fill_busy),
    .fill_done     (fill_done),
    .mem_writeMem  (mem_writeMem),
    .mem_writeData (mem_writeData),
    .mem_dataAddr  (mem_dataAddr),
    .mem_data_out  (mem_data_out)
  );

  // Data memory: combinational read, write at the clock edge.
  always @(posedge clk) if (mem_writeMem) mem[mem_dataAddr] <= mem_writeData;
  assign mem_data_out = mem[mem_dataAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: fill progress as a remaining-word count.
  int                m_fill_left = 0, m_fill_pos = 0, m_starve = 0;
  logic [LENGTH-1:0] m_fill_val = '0, m_crd = '0, m_erd = '0;
  bit                m_busy = 0, m_done = 0, m_crv = 0, m_erv = 0;
  logic [LENGTH-1:0] ref_mem [DEPTH] = '{default: '0};

  always @(negedge clk) begin
    bit run, cg, eg, we, fin, idle;
    int addr;
    logic [LENGTH-1:0] wd, rd;
    run = reset_n && (m_fill_left > 0);
    cg = 0;
    eg = 0;
    if (reset_n && !run) begin
      if (ext_req && m_starve == STARVE_LIMIT) eg = 1;
      else if (core_req)                       cg = 1;
      else if (ext_req)                        eg = 1;
    end
    we = 0; addr = 0; wd = '0;
    if (run)     begin we = 1;       addr = m_fill_pos; wd = m_fill_val; end
    else if (cg) begin we = core_we; addr = core_addr;  wd = core_wdata; end
    else if (eg) begin we = ext_we;  addr = ext_addr;   wd = ext_wdata;  end

    check("core_gnt", core_gnt, cg);
    check("ext_gnt", ext_gnt, eg);
    check("mem_writeMem", mem_writeMem, we);
    check("mem_dataAddr", mem_dataAddr, addr);
    if (we || !(cg || eg)) check("mem_writeData", mem_writeData, wd);
    check("core_rvalid", core_rvalid, m_crv);
    check("core_rdata", core_rdata, m_crd);
    check("ext_rvalid", ext_rvalid, m_erv);
    check("ext_rdata", ext_rdata, m_erd);
    check("fill_busy", fill_busy, m_busy);
    check("fill_done", fill_done, m_done);

    if (!reset_n) begin
      m_fill_left = 0; m_fill_pos = 0; m_fill_val = '0; m_busy = 0; m_done = 0;
      m_starve = 0; m_crv = 0; m_erv = 0; m_crd = '0; m_erd = '0;
    end else begin
      rd = ref_mem[addr];
      m_crv = cg && !core_we;
      if (m_crv) m_crd = rd;
      m_erv = eg && !ext_we;
      if (m_erv) m_erd = rd;
      if (we) ref_mem[addr] = wd;
      if (eg || !ext_req) m_starve = 0;
      else if (cg && m_starve < STARVE_LIMIT) m_starve++;
      idle = (m_fill_left == 0) && !m_done;
      fin = 0;
      if (run) begin
        m_fill_pos++;
        m_fill_left--;
        fin = (m_fill_left == 0);
      end
      m_done = fin;
      if (idle && fill_start) begin
        m_fill_left = DEPTH; m_fill_pos = 0; m_fill_val = fill_value;
      end
      m_busy = (m_fill_left > 0) || m_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    core_req = 0; core_we = 0; ext_req = 0; ext_we = 0; fill_start = 0;
  endtask

  task automatic core_read_check(input string name, input logic [AW-1:0] a,
                                 input logic [LENGTH-1:0] exp);
    core_req = 1; core_we = 0; core_addr = a;
    step();
    check(name, core_rdata, exp);
    clear_reqs();
  endtask

  task automatic run_fill(input logic [LENGTH-1:0] v);
    int n;
    n = 0;
    clear_reqs();
    fill_start = 1; fill_value = v;
    step();
    fill_start = 0;
    while (fill_busy && n < 400) begin
      step();
      n++;
    end
    check("fill busy length", n, 257);
  endtask

  initial begin
    int busy_cycles, done_pulses, run_gnts, bad;
    bit seen, gc, ge;

    // Reset, with a core request pending to show grants are held off.
    core_req = 1;
    step(); step();
    check("reset core_gnt", core_gnt, 0);
    check("reset core_rvalid", core_rvalid, 0);
    check("reset core_rdata", core_rdata, 0);
    check("reset fill_busy", fill_busy, 0);
    clear_reqs();
    reset_n = 1;

    // Core write then read back.
    core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 16'h1234;
    #1 check("t1 write gnt", core_gnt, 1);
    step();
    core_we = 0;
    #1 check("t1 read gnt", core_gnt, 1);
    step();
    check("t1 core_rvalid", core_rvalid, 1);
    check("t1 core_rdata", core_rdata, 16'h1234);
    check("t1 ext_rvalid", ext_rvalid, 0);
    clear_reqs();
    step();
    check("t1 rvalid pulse", core_rvalid, 0);
    check("t1 rdata hold", core_rdata, 16'h1234);

    // Both ports reading continuously: four core grants, then one ext grant.
    for (int i = 0; i < 15; i++) begin
      core_req = 1; ext_req = 1; core_we = 0; ext_we = 0;
      core_addr = 8'h10; ext_addr = 8'h11;
      #1;
      check("t2 core_gnt", core_gnt, (i % 5) != 4);
      check("t2 ext_gnt", ext_gnt, (i % 5) == 4);
      step();
    end
    clear_reqs();
    step();

    // External write then read at the top address.
    ext_req = 1; ext_we = 1; ext_addr = 8'hFF; ext_wdata = 16'hBEEF;
    #1 check("t6 ext write gnt", ext_gnt, 1);
    step();
    ext_we = 0;
    step();
    check("t6 ext_rvalid", ext_rvalid, 1);
    check("t6 ext_rdata", ext_rdata, 16'hBEEF);
    check("t6 core_rvalid", core_rvalid, 0);
    clear_reqs();
    step();
    check("t6 ext rvalid pulse", ext_rvalid, 0);

    // Fill with 0xA5A5 started alongside a core read; a second start mid-fill is ignored.
    fill_start = 1; fill_value = 16'hA5A5;
    core_req = 1; core_we = 0; core_addr = 8'h10;
    #1 check("t3 core_gnt with fill_start", core_gnt, 1);
    step();
    fill_start = 0;
    busy_cycles = 0; done_pulses = 0; run_gnts = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 10) begin fill_start = 1; fill_value = 16'h0000; end
      else fill_start = 0;
      #1;
      if (fill_busy) busy_cycles++;
      if (fill_done) done_pulses++;
      if (fill_busy && !fill_done && core_gnt) run_gnts++;
      if (fill_busy) seen = 1;
      else if (seen) break;
      step();
    end
    clear_reqs();
    check("t3 busy cycles", busy_cycles, 257);
    check("t3 done pulses", done_pulses, 1);
    check("t3 core grants during fill", run_gnts, 0);
    core_read_check("t3 read 0x00", 8'h00, 16'hA5A5);
    core_read_check("t3 read 0x7F", 8'h7F, 16'hA5A5);
    core_read_check("t3 read 0xFF", 8'hFF, 16'hA5A5);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      core_req = 1; core_we = 0; core_addr = AW'(a);
      step();
      if (core_rdata !== 16'hA5A5) bad++;
    end
    clear_reqs();
    check("t4 words not A5A5", bad, 0);

    // Clear to zero, then abandon an 0xA5A5 fill with reset at address 0x40.
    run_fill(16'h0000);
    fill_start = 1; fill_value = 16'hA5A5;
    step();
    fill_start = 0;
    repeat (64) step();
    #1 check("t5 fill at 0x40", mem_dataAddr, 8'h40);
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
    check("t5 busy after reset", fill_busy, 0);
    check("t5 done after reset", fill_done, 0);
    done_pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (fill_done) done_pulses++;
    end
    check("t5 no done pulse", done_pulses, 0);
    core_read_check("t5 read 0x00", 8'h00, 16'hA5A5);
    core_read_check("t5 read 0x3F", 8'h3F, 16'hA5A5);
    core_read_check("t5 read 0x40", 8'h40, 16'h0000);

    // Random traffic; requesters hold their fields until granted.
    gc = 1; ge = 1;
    for (int c = 0; c < 700; c++) begin
      if (gc) begin
        core_req   = ($urandom_range(0, 2) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 15));
        core_wdata = LENGTH'($urandom);
      end
      if (ge) begin
        ext_req   = ($urandom_range(0, 2) != 0);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = AW'($urandom_range(0, 15));
        ext_wdata = LENGTH'($urandom);
      end
      fill_start = ($urandom_range(0, 249) == 0);
      fill_value = LENGTH'($urandom);
      reset_n    = ($urandom_range(0, 299) != 0);
      #2;
      gc = !core_req || core_gnt;
      ge = !ext_req || ext_gnt;
      step();
    end
    reset_n = 1;
    clear_reqs();
    for (int c = 0; c < 400 && fill_busy; c++) step();
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
